// File: rtl/laser_palette_pkg.sv
// Shared types, reset palette and channel scaling helper for the laser palette fader.
package laser_palette_pkg;

  localparam int CH_W_DEFAULT = 4;
  localparam int N_DEFAULTS   = 8;

  typedef struct packed {
    logic [CH_W_DEFAULT-1:0] r;
    logic [CH_W_DEFAULT-1:0] g;
    logic [CH_W_DEFAULT-1:0] b;
  } rgb_t;

  localparam rgb_t DEFAULT_PALETTE [N_DEFAULTS] = '{
    rgb_t'(12'h000), rgb_t'(12'hF81), rgb_t'(12'h638), rgb_t'(12'h1BE),
    rgb_t'(12'hFE1), rgb_t'(12'hD22), rgb_t'(12'h338), rgb_t'(12'hAD3)
  };

  // (ch * (eff+1)) >> int_w, so full intensity returns the channel unchanged
  function automatic logic [31:0] scale_ch(input logic [31:0] ch,
                                           input logic [31:0] eff,
                                           input int          int_w);
    logic [63:0] prod;
    prod = 64'(ch) * (64'(eff) + 64'd1);
    return 32'(prod >> int_w);
  endfunction

endpackage

// File: rtl/laser_intensity_decay.sv
// Per-entry intensity registers: pluck loads full scale, a shared tick prescaler decays them.
module laser_intensity_decay
  import laser_palette_pkg::*;
#(
  parameter int N_ENT       = 8,
  parameter int INT_W       = 4,
  parameter int DECAY_TICKS = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [N_ENT-1:0]       pluck_i,
  input  logic                   tick_i,
  output logic [N_ENT*INT_W-1:0] inten_o
);

  localparam int PRE_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_TICKS - 1);
  localparam logic [INT_W-1:0] INT_MAX  = '1;

  logic [PRE_W-1:0] pre_cnt;
  logic             decay_step;
  logic [INT_W-1:0] inten [N_ENT];

  assign decay_step = tick_i && (pre_cnt == PRE_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_cnt <= '0;
    end else if (tick_i) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end
  end

  // pluck has priority so a held pluck pins the entry at full scale
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_ENT; i++) inten[i] <= '0;
    end else begin
      for (int i = 0; i < N_ENT; i++) begin
        if (pluck_i[i]) begin
          inten[i] <= INT_MAX;
        end else if (decay_step && (inten[i] != '0)) begin
          inten[i] <= inten[i] - 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_ENT; g++) begin : g_pack
    assign inten_o[g*INT_W +: INT_W] = inten[g];
  end

endmodule

// File: rtl/laser_palette_fader.sv
// Writable colour palette whose entries are scaled by a pluck-triggered fading intensity.
module laser_palette_fader
  import laser_palette_pkg::*;
#(
  parameter int IDX_W       = 3,
  parameter int CH_W        = 4,
  parameter int INT_W       = 4,
  parameter int DECAY_TICKS = 4,
  localparam int N_ENT      = 2**IDX_W
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   pix_valid_i,
  input  logic [IDX_W-1:0]       pix_index_i,
  input  logic                   mode_i,
  input  logic [N_ENT-1:0]       pluck_i,
  input  logic                   tick_i,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_addr_i,
  input  logic [3*CH_W-1:0]      wr_data_i,
  output logic                   pix_valid_o,
  output logic [CH_W-1:0]        red_o,
  output logic [CH_W-1:0]        green_o,
  output logic [CH_W-1:0]        blue_o,
  output logic [N_ENT*INT_W-1:0] inten_o
);

  localparam logic [INT_W-1:0] INT_MAX = '1;

  // Reset colours are 4-bit; wider channels are left-aligned with zero low bits
  function automatic logic [3*CH_W-1:0] default_rgb(input int idx);
    rgb_t              d;
    logic [CH_W+3:0]   r_w, g_w, b_w;
    d   = (idx < N_DEFAULTS) ? DEFAULT_PALETTE[idx[2:0]] : '0;
    r_w = {d.r, {CH_W{1'b0}}};
    g_w = {d.g, {CH_W{1'b0}}};
    b_w = {d.b, {CH_W{1'b0}}};
    return {r_w[CH_W+3 -: CH_W], g_w[CH_W+3 -: CH_W], b_w[CH_W+3 -: CH_W]};
  endfunction

  logic [3*CH_W-1:0] pal [N_ENT];
  logic [3*CH_W-1:0] rd_rgb;
  logic [INT_W-1:0]  rd_int;
  logic [INT_W-1:0]  eff_int;

  logic              s1_valid;
  logic [3*CH_W-1:0] s1_rgb;
  logic [INT_W-1:0]  s1_int;

  laser_intensity_decay #(
    .N_ENT      (N_ENT),
    .INT_W      (INT_W),
    .DECAY_TICKS(DECAY_TICKS)
  ) u_decay (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .pluck_i(pluck_i),
    .tick_i (tick_i),
    .inten_o(inten_o)
  );

  // Register array rather than RAM so reset can restore the default palette
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_ENT; i++) pal[i] <= default_rgb(i);
    end else if (wr_en_i) begin
      pal[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_rgb  = pal[pix_index_i];
  assign rd_int  = inten_o[pix_index_i*INT_W +: INT_W];
  assign eff_int = mode_i ? rd_int : INT_MAX;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_rgb   <= '0;
      s1_int   <= '0;
    end else begin
      s1_valid <= pix_valid_i;
      s1_rgb   <= rd_rgb;
      s1_int   <= eff_int;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid_o <= 1'b0;
      red_o       <= '0;
      green_o     <= '0;
      blue_o      <= '0;
    end else begin
      pix_valid_o <= s1_valid;
      red_o       <= CH_W'(scale_ch(32'(s1_rgb[3*CH_W-1 -: CH_W]), 32'(s1_int), INT_W));
      green_o     <= CH_W'(scale_ch(32'(s1_rgb[2*CH_W-1 -: CH_W]), 32'(s1_int), INT_W));
      blue_o      <= CH_W'(scale_ch(32'(s1_rgb[CH_W-1 -: CH_W]),   32'(s1_int), INT_W));
    end
  end

endmodule

// File: tb/tb_laser_palette_fader.sv
// Directed self-checking bench for laser_palette_fader with hand-computed expectations.
module tb_laser_palette_fader;

  localparam int IDX_W = 3;
  localparam int CH_W  = 4;
  localparam int INT_W = 4;
  localparam int N_ENT = 8;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              pix_valid_i;
  logic [IDX_W-1:0]  pix_index_i;
  logic              mode_i;
  logic [N_ENT-1:0]  pluck_i;
  logic              tick_i;
  logic              wr_en_i;
  logic [IDX_W-1:0]  wr_addr_i;
  logic [3*CH_W-1:0] wr_data_i;
  logic              pix_valid_o;
  logic [CH_W-1:0]   red_o, green_o, blue_o;
  logic [N_ENT*INT_W-1:0] inten_o;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_def [8] = '{12'h000, 12'hF81, 12'h638, 12'h1BE,
                               12'hFE1, 12'hD22, 12'h338, 12'hAD3};

  laser_palette_fader #(
    .IDX_W(IDX_W), .CH_W(CH_W), .INT_W(INT_W), .DECAY_TICKS(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid_i(pix_valid_i), .pix_index_i(pix_index_i), .mode_i(mode_i),
    .pluck_i(pluck_i), .tick_i(tick_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .pix_valid_o(pix_valid_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .inten_o(inten_o)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    pix_valid_i = 1'b0; pix_index_i = '0; mode_i = 1'b0; pluck_i = '0;
    tick_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    Reset_n = 1'b0;
    step(); step();
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({pix_valid_o, red_o, green_o, blue_o} !== 13'h0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", {pix_valid_o, red_o, green_o, blue_o});
    end
    checks++;
    if (inten_o !== '0) begin
      errors++; $display("[TB] FAIL reset_inten: got %h expected 0", inten_o);
    end
  endtask

  task automatic test_static_stream();
    for (int c = 0; c < 10; c++) begin
      pix_valid_i = (c < 8); pix_index_i = IDX_W'(c); mode_i = 1'b0;
      step();
      if (c >= 1 && c <= 8) begin
        checks++;
        if ({pix_valid_o, red_o, green_o, blue_o} !== {1'b1, exp_def[c-1]}) begin
          errors++; $display("[TB] FAIL static_idx%0d: got %h expected %h", c-1,
                             {pix_valid_o, red_o, green_o, blue_o}, {1'b1, exp_def[c-1]});
        end
      end else begin
        checks++;
        if (pix_valid_o !== 1'b0) begin
          errors++; $display("[TB] FAIL static_valid_c%0d: got %b expected 0", c, pix_valid_o);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_rbw();
    pix_valid_i = 1'b1; pix_index_i = 3'd5; mode_i = 1'b0;
    wr_en_i = 1'b1; wr_addr_i = 3'd5; wr_data_i = 12'h0F0;
    step();
    wr_en_i = 1'b0;
    step();
    checks++;
    if ({red_o, green_o, blue_o} !== 12'hD22) begin
      errors++; $display("[TB] FAIL rbw_old: got %h expected d22", {red_o, green_o, blue_o});
    end
    step();
    checks++;
    if ({red_o, green_o, blue_o} !== 12'h0F0) begin
      errors++; $display("[TB] FAIL rbw_new: got %h expected 0f0", {red_o, green_o, blue_o});
    end
    checks++;
    if (inten_o[5*INT_W +: INT_W] !== 4'd0) begin
      errors++; $display("[TB] FAIL write_keeps_inten: got %h expected 0", inten_o[5*INT_W +: INT_W]);
    end
    idle_inputs();
  endtask

  task automatic test_pluck_decay();
    pluck_i = 8'b0000_0010;
    step();
    pluck_i = '0;
    checks++;
    if (inten_o[1*INT_W +: INT_W] !== 4'd15) begin
      errors++; $display("[TB] FAIL pluck_full: got %0d expected 15", inten_o[1*INT_W +: INT_W]);
    end
    for (int t = 0; t < 3; t++) begin
      tick_i = 1'b1; step(); tick_i = 1'b0; step();
    end
    checks++;
    if (inten_o[1*INT_W +: INT_W] !== 4'd15) begin
      errors++; $display("[TB] FAIL three_ticks: got %0d expected 15", inten_o[1*INT_W +: INT_W]);
    end
    tick_i = 1'b1; step(); tick_i = 1'b0;
    checks++;
    if (inten_o[1*INT_W +: INT_W] !== 4'd14) begin
      errors++; $display("[TB] FAIL four_ticks: got %0d expected 14", inten_o[1*INT_W +: INT_W]);
    end
    pix_valid_i = 1'b1; pix_index_i = 3'd1; mode_i = 1'b1;
    step(); pix_valid_i = 1'b0; step();
    checks++;
    if ({pix_valid_o, red_o, green_o, blue_o} !== {1'b1, 12'hE70}) begin
      errors++; $display("[TB] FAIL fade_idx1: got %h expected 1e70", {pix_valid_o, red_o, green_o, blue_o});
    end
    idle_inputs();
  endtask

  task automatic test_pluck_vs_decay();
    for (int t = 0; t < 3; t++) begin
      tick_i = 1'b1; step(); tick_i = 1'b0; step();
    end
    tick_i = 1'b1; pluck_i = 8'b0000_1000;
    step();
    tick_i = 1'b0; pluck_i = '0;
    checks++;
    if (inten_o[3*INT_W +: INT_W] !== 4'd15) begin
      errors++; $display("[TB] FAIL pluck_wins: got %0d expected 15", inten_o[3*INT_W +: INT_W]);
    end
    checks++;
    if (inten_o[2*INT_W +: INT_W] !== 4'd0) begin
      errors++; $display("[TB] FAIL sat_zero: got %0d expected 0", inten_o[2*INT_W +: INT_W]);
    end
    checks++;
    if (inten_o[1*INT_W +: INT_W] !== 4'd13) begin
      errors++; $display("[TB] FAIL decay_idx1: got %0d expected 13", inten_o[1*INT_W +: INT_W]);
    end
    pix_valid_i = 1'b1; pix_index_i = 3'd3; mode_i = 1'b1;
    step(); pix_valid_i = 1'b0; step();
    checks++;
    if ({red_o, green_o, blue_o} !== 12'h1BE) begin
      errors++; $display("[TB] FAIL full_passes: got %h expected 1be", {red_o, green_o, blue_o});
    end
    idle_inputs();
  endtask

  task automatic test_mode_toggle();
    apply_reset();
    pix_valid_i = 1'b1; pix_index_i = 3'd4; mode_i = 1'b1;
    step();
    mode_i = 1'b0;
    step();
    checks++;
    if ({pix_valid_o, red_o, green_o, blue_o} !== {1'b1, 12'h000}) begin
      errors++; $display("[TB] FAIL fade_zero: got %h expected 1000", {pix_valid_o, red_o, green_o, blue_o});
    end
    pix_valid_i = 1'b0;
    step();
    checks++;
    if ({pix_valid_o, red_o, green_o, blue_o} !== {1'b1, 12'hFE1}) begin
      errors++; $display("[TB] FAIL static_again: got %h expected 1fe1", {pix_valid_o, red_o, green_o, blue_o});
    end
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    wr_en_i = 1'b1; wr_addr_i = 3'd2; wr_data_i = 12'h123;
    step();
    wr_en_i = 1'b0;
    pix_valid_i = 1'b1; pix_index_i = 3'd2; mode_i = 1'b0; pluck_i = 8'h40;
    step();
    pluck_i = '0;
    step();
    checks++;
    if ({pix_valid_o, red_o, green_o, blue_o} !== {1'b1, 12'h123}) begin
      errors++; $display("[TB] FAIL written_val: got %h expected 1123", {pix_valid_o, red_o, green_o, blue_o});
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({pix_valid_o, red_o, green_o, blue_o} !== 13'h0) begin
      errors++; $display("[TB] FAIL async_clear: got %h expected 0", {pix_valid_o, red_o, green_o, blue_o});
    end
    checks++;
    if (inten_o !== '0) begin
      errors++; $display("[TB] FAIL async_inten: got %h expected 0", inten_o);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    pix_valid_i = 1'b1; pix_index_i = 3'd2;
    step();
    pix_index_i = 3'd5;
    step();
    checks++;
    if ({pix_valid_o, red_o, green_o, blue_o} !== {1'b1, 12'h638}) begin
      errors++; $display("[TB] FAIL restored_idx2: got %h expected 1638", {pix_valid_o, red_o, green_o, blue_o});
    end
    pix_valid_i = 1'b0;
    step();
    checks++;
    if ({red_o, green_o, blue_o} !== 12'hD22) begin
      errors++; $display("[TB] FAIL restored_idx5: got %h expected d22", {red_o, green_o, blue_o});
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    Reset_n = 1'b0;
    test_reset();
    test_static_stream();
    test_write_rbw();
    test_pluck_decay();
    test_pluck_vs_decay();
    test_mode_toggle();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
